// File: rtl/ifetch_pc_pkg.sv
// Shared encodings for the instruction-fetch / PC stage: FSM states and
// the bit positions of the control unit's next-PC select bus.
package ifetch_pc_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StFetch = 2'd1,
    StExec  = 2'd2,
    StHalt  = 2'd3
  } state_e;

  localparam int unsigned PcnBr = 0;
  localparam int unsigned PcnJ  = 1;
  localparam int unsigned PcnJr = 2;

  localparam logic [31:0] InstrWidthBytes = 32'd4;

endpackage

// File: rtl/pc_next_calc.sv
// Combinational next-PC selection (jr > j > branch > sequential) and the
// jr-target alignment check.
module pc_next_calc
  import ifetch_pc_pkg::*;
(
  input  logic [31:0] pc_plus4,
  input  logic [31:0] imm_ext,
  input  logic [25:0] jaddr,
  input  logic [31:0] rs_data,
  input  logic [2:0]  pc_next_c,
  output logic [31:0] next_pc,
  output logic        misaligned
);

  always_comb begin
    next_pc = pc_plus4;
    if (pc_next_c[PcnJr]) begin
      next_pc = rs_data;
    end else if (pc_next_c[PcnJ]) begin
      next_pc = {pc_plus4[31:28], jaddr, 2'b00};
    end else if (pc_next_c[PcnBr]) begin
      // Word offset; wraps modulo 2^32.
      next_pc = pc_plus4 + (imm_ext << 2);
    end
  end

  // j and branch targets are word-aligned by construction.
  assign misaligned = pc_next_c[PcnJr] & (rs_data[1:0] != 2'b00);

endmodule

// File: rtl/ifetch_pc.sv
// Instruction-fetch / PC stage: fetches over a req/ready handshake, presents
// each instruction for one execute cycle, then advances the PC.
module ifetch_pc
  import ifetch_pc_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        run,
  input  logic [2:0]  pc_next_c,
  input  logic [31:0] imm_ext,
  input  logic [25:0] jaddr,
  input  logic [31:0] rs_data,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic [31:0] instr,
  output logic        instr_valid,
  output logic        misalign
);

  state_e      state_q;
  logic [31:0] pc_q;
  logic [31:0] instr_q;
  logic        req_q;
  logic        valid_q;
  logic        misalign_q;

  logic [31:0] next_pc;
  logic        target_misaligned;

  assign pc_plus4 = pc_q + InstrWidthBytes;

  pc_next_calc u_pc_next_calc (
    .pc_plus4   (pc_plus4),
    .imm_ext    (imm_ext),
    .jaddr      (jaddr),
    .rs_data    (rs_data),
    .pc_next_c  (pc_next_c),
    .next_pc    (next_pc),
    .misaligned (target_misaligned)
  );

  // Strobes are registered alongside the state so they switch only on edges.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      pc_q       <= RESET_PC;
      instr_q    <= 32'h0;
      req_q      <= 1'b0;
      valid_q    <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (run) begin
            state_q <= StFetch;
            req_q   <= 1'b1;
          end
        end
        StFetch: begin
          if (imem_ready) begin
            instr_q <= imem_rdata;
            state_q <= StExec;
            req_q   <= 1'b0;
            valid_q <= 1'b1;
          end
        end
        StExec: begin
          valid_q <= 1'b0;
          pc_q    <= next_pc;
          if (target_misaligned) begin
            state_q    <= StHalt;
            misalign_q <= 1'b1;
          end else if (run) begin
            state_q <= StFetch;
            req_q   <= 1'b1;
          end else begin
            state_q <= StIdle;
          end
        end
        StHalt: begin
          state_q <= StHalt;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign imem_req    = req_q;
  assign imem_addr   = pc_q;
  assign pc          = pc_q;
  assign instr       = instr_q;
  assign instr_valid = valid_q;
  assign misalign    = misalign_q;

endmodule

// File: tb/tb_ifetch_pc.sv
// Self-checking bench for ifetch_pc: directed scenarios plus a randomized
// instruction stream checked against an arithmetic next-PC model.
module tb_ifetch_pc;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        run;
  logic [2:0]  pc_next_c;
  logic [31:0] imm_ext;
  logic [25:0] jaddr;
  logic [31:0] rs_data;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic [31:0] instr;
  logic        instr_valid;
  logic        misalign;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  ifetch_pc #(.RESET_PC(RESET_PC)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .run         (run),
    .pc_next_c   (pc_next_c),
    .imm_ext     (imm_ext),
    .jaddr       (jaddr),
    .rs_data     (rs_data),
    .imem_ready  (imem_ready),
    .imem_rdata  (imem_rdata),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .pc          (pc),
    .pc_plus4    (pc_plus4),
    .instr       (instr),
    .instr_valid (instr_valid),
    .misalign    (misalign)
  );

  // Reference next-PC rule: jr > j > branch > sequential.
  function automatic logic [31:0] ref_next(input logic [31:0] p, input logic [2:0] sel,
                                           input logic [31:0] imm, input logic [25:0] ja,
                                           input logic [31:0] rs);
    logic [31:0] p4;
    p4 = p + 32'd4;
    if (sel[2]) return rs;
    if (sel[1]) return {p4[31:28], ja, 2'b00};
    if (sel[0]) return p4 + imm * 32'd4;
    return p4;
  endfunction

  task automatic idle_inputs();
    run = 1'b0; pc_next_c = 3'b000; imm_ext = 32'h0; jaddr = 26'h0; rs_data = 32'h0;
    imem_ready = 1'b0; imem_rdata = 32'h0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Reset, raise run, and stop at the first FETCH cycle of RESET_PC.
  task automatic start_run();
    do_reset();
    run = 1'b1;
    @(negedge clk);
  endtask

  // Drives one instruction from a FETCH cycle through EXEC; no checking.
  task automatic exec_one(input int waits, input logic [2:0] sel, input logic [31:0] imm,
                          input logic [25:0] ja, input logic [31:0] rs);
    imem_ready = 1'b0;
    repeat (waits) @(negedge clk);
    imem_ready = 1'b1; imem_rdata = $urandom;
    pc_next_c = sel; imm_ext = imm; jaddr = ja; rs_data = rs;
    @(negedge clk);
    imem_ready = 1'b0;
    @(negedge clk);
    pc_next_c = 3'b000;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    tests++; if (pc !== RESET_PC) begin fails++; $display("FAIL reset_pc: got %h want %h", pc, RESET_PC); end
    tests++; if (instr !== 32'h0) begin fails++; $display("FAIL reset_instr: got %h want 0", instr); end
    tests++; if (imem_req !== 1'b0) begin fails++; $display("FAIL reset_req: got %b want 0", imem_req); end
    tests++; if (instr_valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b want 0", instr_valid); end
    tests++; if (misalign !== 1'b0) begin fails++; $display("FAIL reset_misalign: got %b want 0", misalign); end
    tests++; if (pc_plus4 !== RESET_PC + 32'd4) begin fails++; $display("FAIL reset_pc_plus4: got %h want %h", pc_plus4, RESET_PC + 32'd4); end
  endtask

  task automatic test_sequential();
    logic [31:0] exp_pc, rd;
    do_reset();
    run = 1'b1; imem_ready = 1'b1;
    exp_pc = RESET_PC;
    for (int k = 1; k <= 12; k++) begin
      rd = $urandom; imem_rdata = rd;
      @(negedge clk);
      if (k % 2 == 1) begin
        tests++; if (imem_req !== 1'b1 || instr_valid !== 1'b0 || imem_addr !== exp_pc) begin
          fails++; $display("FAIL seq_fetch k=%0d: req=%b valid=%b addr=%h want req=1 valid=0 addr=%h", k, imem_req, instr_valid, imem_addr, exp_pc);
        end
      end else begin
        tests++; if (instr_valid !== 1'b1 || imem_req !== 1'b0 || instr !== rd) begin
          fails++; $display("FAIL seq_exec k=%0d: valid=%b req=%b instr=%h want valid=1 req=0 instr=%h", k, instr_valid, imem_req, instr, rd);
        end
        exp_pc = exp_pc + 32'd4;
      end
    end
  endtask

  task automatic test_mem_wait();
    logic [31:0] rd;
    start_run();
    exec_one(0, 3'b000, 32'h0, 26'h0, 32'h0);
    exec_one(0, 3'b000, 32'h0, 26'h0, 32'h0);
    imem_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tests++; if (imem_req !== 1'b1 || imem_addr !== 32'h8 || instr_valid !== 1'b0) begin
        fails++; $display("FAIL wait_hold k=%0d: req=%b addr=%h valid=%b want req=1 addr=8 valid=0", k, imem_req, imem_addr, instr_valid);
      end
      if (k < 3) @(negedge clk);
    end
    rd = $urandom; imem_ready = 1'b1; imem_rdata = rd;
    @(negedge clk);
    tests++; if (instr_valid !== 1'b1 || instr !== rd) begin
      fails++; $display("FAIL wait_exec: valid=%b instr=%h want valid=1 instr=%h", instr_valid, instr, rd);
    end
    imem_ready = 1'b0;
    @(negedge clk);
    tests++; if (instr_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'hC) begin
      fails++; $display("FAIL wait_after: valid=%b req=%b addr=%h want valid=0 req=1 addr=c", instr_valid, imem_req, imem_addr);
    end
  endtask

  // Leaves the core in FETCH at pc 0x100 for test_misalign.
  task automatic test_branch_priority();
    start_run();
    repeat (4) exec_one(0, 3'b000, 32'h0, 26'h0, 32'h0);
    tests++; if (imem_addr !== 32'h10) begin fails++; $display("FAIL br_setup: got %h want 10", imem_addr); end
    imem_ready = 1'b1; imem_rdata = $urandom;
    pc_next_c = 3'b001; imm_ext = 32'hFFFF_FFFC;
    @(negedge clk);
    tests++; if (pc !== 32'h10 || pc_plus4 !== 32'h14) begin
      fails++; $display("FAIL br_exec_pc: pc=%h pc_plus4=%h want 10/14", pc, pc_plus4);
    end
    imem_ready = 1'b0;
    @(negedge clk);
    pc_next_c = 3'b000;
    tests++; if (imem_addr !== 32'h4 || imem_req !== 1'b1) begin
      fails++; $display("FAIL branch_target: addr=%h req=%b want 4/1", imem_addr, imem_req);
    end
    exec_one(0, 3'b111, 32'h1234, 26'h40, 32'h200);
    tests++; if (imem_addr !== 32'h200) begin fails++; $display("FAIL prio_jr: got %h want 200", imem_addr); end
    exec_one(1, 3'b010, 32'h1234, 26'h40, 32'h300);
    tests++; if (imem_addr !== 32'h100) begin fails++; $display("FAIL prio_j: got %h want 100", imem_addr); end
  endtask

  task automatic test_misalign();
    logic [31:0] r;
    exec_one(0, 3'b100, 32'h0, 26'h0, 32'h202);
    for (int k = 0; k < 6; k++) begin
      tests++; if (misalign !== 1'b1 || imem_req !== 1'b0 || instr_valid !== 1'b0 || pc !== 32'h202) begin
        fails++; $display("FAIL halt k=%0d: mis=%b req=%b valid=%b pc=%h want 1/0/0/202", k, misalign, imem_req, instr_valid, pc);
      end
      r = $urandom;
      run = 1'b1; imem_ready = 1'b1; pc_next_c = r[2:0]; rs_data = $urandom;
      @(negedge clk);
    end
    idle_inputs();
    rst_n = 1'b0;
    @(negedge clk);
    tests++; if (misalign !== 1'b0 || pc !== RESET_PC || imem_req !== 1'b0) begin
      fails++; $display("FAIL halt_reset: mis=%b pc=%h req=%b want 0/%h/0", misalign, pc, imem_req, RESET_PC);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_run_drop();
    logic [31:0] rd;
    start_run();
    run = 1'b0; imem_ready = 1'b0;
    @(negedge clk);
    tests++; if (imem_req !== 1'b1 || imem_addr !== RESET_PC) begin
      fails++; $display("FAIL drop_hold: req=%b addr=%h want 1/%h", imem_req, imem_addr, RESET_PC);
    end
    rd = $urandom; imem_ready = 1'b1; imem_rdata = rd;
    @(negedge clk);
    tests++; if (instr_valid !== 1'b1 || instr !== rd) begin
      fails++; $display("FAIL drop_exec: valid=%b instr=%h want 1/%h", instr_valid, instr, rd);
    end
    imem_ready = 1'b0;
    repeat (2) begin
      @(negedge clk);
      tests++; if (imem_req !== 1'b0 || instr_valid !== 1'b0 || pc !== RESET_PC + 32'd4 || instr !== rd) begin
        fails++; $display("FAIL drop_idle: req=%b valid=%b pc=%h instr=%h want 0/0/%h/%h", imem_req, instr_valid, pc, instr, RESET_PC + 32'd4, rd);
      end
    end
    run = 1'b1;
    @(negedge clk);
    tests++; if (imem_req !== 1'b1 || imem_addr !== RESET_PC + 32'd4) begin
      fails++; $display("FAIL drop_resume: req=%b addr=%h want 1/%h", imem_req, imem_addr, RESET_PC + 32'd4);
    end
  endtask

  task automatic test_reset_mid_fetch();
    start_run();
    exec_one(0, 3'b000, 32'h0, 26'h0, 32'h0);
    imem_ready = 1'b0; rst_n = 1'b0;
    @(negedge clk);
    tests++; if (imem_req !== 1'b0 || pc !== RESET_PC || instr !== 32'h0) begin
      fails++; $display("FAIL rst_mid: req=%b pc=%h instr=%h want 0/%h/0", imem_req, pc, instr, RESET_PC);
    end
    rst_n = 1'b1;
    @(negedge clk);
    tests++; if (imem_req !== 1'b1 || imem_addr !== RESET_PC) begin
      fails++; $display("FAIL rst_mid_refetch: req=%b addr=%h want 1/%h", imem_req, imem_addr, RESET_PC);
    end
  endtask

  task automatic test_random();
    logic [31:0] exp_pc, rd, r, imm, rs;
    logic [2:0]  sel;
    logic [25:0] ja;
    int          waits;
    start_run();
    exp_pc = RESET_PC;
    for (int n = 0; n < 60; n++) begin
      waits = $urandom_range(0, 3);
      imem_ready = 1'b0;
      for (int w = 0; w <= waits; w++) begin
        tests++; if (imem_req !== 1'b1 || imem_addr !== exp_pc || instr_valid !== 1'b0) begin
          fails++; $display("FAIL rnd_fetch n=%0d w=%0d: req=%b addr=%h valid=%b want 1/%h/0", n, w, imem_req, imem_addr, instr_valid, exp_pc);
        end
        if (w < waits) @(negedge clk);
      end
      r = $urandom; sel = r[2:0];
      r = $urandom; imm = {{16{r[15]}}, r[15:0]};
      r = $urandom; ja = r[25:0];
      rs = $urandom & 32'hFFFF_FFFC;
      rd = $urandom;
      imem_ready = 1'b1; imem_rdata = rd;
      pc_next_c = sel; imm_ext = imm; jaddr = ja; rs_data = rs;
      @(negedge clk);
      tests++; if (instr_valid !== 1'b1 || instr !== rd || pc !== exp_pc || pc_plus4 !== exp_pc + 32'd4) begin
        fails++; $display("FAIL rnd_exec n=%0d: valid=%b instr=%h pc=%h p4=%h want 1/%h/%h/%h", n, instr_valid, instr, pc, pc_plus4, rd, exp_pc, exp_pc + 32'd4);
      end
      exp_pc = ref_next(exp_pc, sel, imm, ja, rs);
      imem_ready = 1'b0;
      @(negedge clk);
      pc_next_c = 3'b000;
    end
    tests++; if (misalign !== 1'b0) begin fails++; $display("FAIL rnd_misalign: got %b want 0", misalign); end
  endtask

  initial begin
    idle_inputs();
    rst_n = 1'b0;
    test_reset();
    test_sequential();
    test_mem_wait();
    test_branch_priority();
    test_misalign();
    test_run_drop();
    test_reset_mid_fetch();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
